// File: rtl/frontend_redirect_ctrl.sv
// Front-end redirect controller: arbitrates backend/decode redirects, hands the
// winning target to fetch, sequences the refill bubble and counts redirects.
module frontend_redirect_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int REFILL_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  be_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] be_redirect_pc,
  input  logic                  dec_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] dec_redirect_pc,
  input  logic                  backend_stall,
  input  logic                  fetch_ready,
  input  logic                  counter_clr,
  output logic                  fetch_redirect_valid,
  output logic [ADDR_WIDTH-1:0] fetch_redirect_pc,
  output logic                  fetch_flush,
  output logic                  decode_flush,
  output logic                  decode_stall,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  be_redirect_cnt,
  output logic [CNT_WIDTH-1:0]  dec_redirect_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FETCH = 2'd1,
    REFILL     = 2'd2
  } state_t;

  localparam logic [3:0] REFILL_INIT = 4'(REFILL_CYCLES);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [3:0]            refill_cnt;
  logic                  be_acc;
  logic                  dec_acc;

  // Decode redirects in WAIT_FETCH/REFILL come from wrong-path code and are dropped.
  assign be_acc  = be_redirect_valid;
  assign dec_acc = dec_redirect_valid && !be_redirect_valid && (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc_q       <= '0;
      refill_cnt <= '0;
    end else if (be_acc) begin
      // A backend redirect overrides any sequence in flight, even a completing handshake.
      state      <= WAIT_FETCH;
      pc_q       <= be_redirect_pc;
      refill_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dec_acc) begin
            state <= WAIT_FETCH;
            pc_q  <= dec_redirect_pc;
          end
        end
        WAIT_FETCH: begin
          if (fetch_ready) begin
            if (REFILL_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state      <= REFILL;
              refill_cnt <= REFILL_INIT;
            end
          end
        end
        REFILL: begin
          refill_cnt <= refill_cnt - 4'd1;
          if (refill_cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      be_redirect_cnt  <= '0;
      dec_redirect_cnt <= '0;
    end else if (counter_clr) begin
      be_redirect_cnt  <= '0;
      dec_redirect_cnt <= '0;
    end else begin
      if (be_acc && !(&be_redirect_cnt))   be_redirect_cnt  <= be_redirect_cnt + 1'b1;
      if (dec_acc && !(&dec_redirect_cnt)) dec_redirect_cnt <= dec_redirect_cnt + 1'b1;
    end
  end

  assign fetch_redirect_valid = (state == WAIT_FETCH);
  assign fetch_redirect_pc    = (state == WAIT_FETCH) ? pc_q : '0;
  assign fetch_flush          = (state == WAIT_FETCH);
  assign decode_flush         = (state != IDLE);
  assign busy                 = (state != IDLE);
  // Flush dominates stall: stall only passes through while idle.
  assign decode_stall         = backend_stall && (state == IDLE);

endmodule

// File: tb/tb_frontend_redirect_ctrl.sv
// Directed bench for frontend_redirect_ctrl with REFILL_CYCLES=2.
module tb_frontend_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        be_redirect_valid, dec_redirect_valid;
  logic [31:0] be_redirect_pc, dec_redirect_pc;
  logic        backend_stall, fetch_ready, counter_clr;
  logic        fetch_redirect_valid, fetch_flush, decode_flush, decode_stall, busy;
  logic [31:0] fetch_redirect_pc;
  logic [15:0] be_redirect_cnt, dec_redirect_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frontend_redirect_ctrl #(.ADDR_WIDTH(32), .REFILL_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .be_redirect_valid(be_redirect_valid), .be_redirect_pc(be_redirect_pc),
    .dec_redirect_valid(dec_redirect_valid), .dec_redirect_pc(dec_redirect_pc),
    .backend_stall(backend_stall), .fetch_ready(fetch_ready), .counter_clr(counter_clr),
    .fetch_redirect_valid(fetch_redirect_valid), .fetch_redirect_pc(fetch_redirect_pc),
    .fetch_flush(fetch_flush), .decode_flush(decode_flush), .decode_stall(decode_stall),
    .busy(busy), .be_redirect_cnt(be_redirect_cnt), .dec_redirect_cnt(dec_redirect_cnt)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    be_redirect_valid = 1'b0; be_redirect_pc = '0;
    dec_redirect_valid = 1'b0; dec_redirect_pc = '0;
    backend_stall = 1'b0; fetch_ready = 1'b0; counter_clr = 1'b0;

    // Reset state
    step();
    check("rst_valid", fetch_redirect_valid, 0);
    check("rst_pc", fetch_redirect_pc, 0);
    check("rst_flush", decode_flush, 0);
    check("rst_busy", busy, 0);
    check("rst_be_cnt", be_redirect_cnt, 0);
    check("rst_dec_cnt", dec_redirect_cnt, 0);
    reset = 1'b1;
    step();

    // Decode redirect 0x1040 with fetch_ready=1
    dec_redirect_valid = 1'b1; dec_redirect_pc = 32'h0000_1040; fetch_ready = 1'b1;
    step();  // cycle N+1
    dec_redirect_valid = 1'b0;
    check("t1_valid", fetch_redirect_valid, 1);
    check("t1_pc", fetch_redirect_pc, 32'h1040);
    check("t1_fflush", fetch_flush, 1);
    check("t1_busy_n1", busy, 1);
    check("t1_dec_cnt", dec_redirect_cnt, 1);
    step();  // N+2 REFILL
    check("t1_valid_n2", fetch_redirect_valid, 0);
    check("t1_dflush_n2", decode_flush, 1);
    step();  // N+3 REFILL
    check("t1_busy_n3", busy, 1);
    step();  // N+4 IDLE
    check("t1_busy_n4", busy, 0);
    check("t1_dflush_n4", decode_flush, 0);

    // Simultaneous backend 0x2000 / decode 0x3000, then fetch stalls 5 cycles
    fetch_ready = 1'b0;
    be_redirect_valid = 1'b1; be_redirect_pc = 32'h2000;
    dec_redirect_valid = 1'b1; dec_redirect_pc = 32'h3000;
    step();
    be_redirect_valid = 1'b0; dec_redirect_valid = 1'b0;
    check("t2_be_cnt", be_redirect_cnt, 1);
    check("t2_dec_cnt", dec_redirect_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", fetch_redirect_valid, 1);
      check("t3_hold_pc", fetch_redirect_pc, 32'h2000);
      if (i < 4) step();
    end
    check("t3_no_refill", busy, 1);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    check("t3_refill_valid", fetch_redirect_valid, 0);
    check("t3_refill_busy", busy, 1);

    // Backend 0x4000 during REFILL, then wrong-path decode 0x5000 in WAIT_FETCH
    be_redirect_valid = 1'b1; be_redirect_pc = 32'h4000;
    step();
    be_redirect_valid = 1'b0;
    check("t4_valid", fetch_redirect_valid, 1);
    check("t4_pc", fetch_redirect_pc, 32'h4000);
    check("t4_be_cnt", be_redirect_cnt, 2);
    dec_redirect_valid = 1'b1; dec_redirect_pc = 32'h5000;
    step();
    dec_redirect_valid = 1'b0;
    check("t4_pc_kept", fetch_redirect_pc, 32'h4000);
    check("t4_dec_dropped", dec_redirect_cnt, 1);

    // Backend redirect coinciding with a fetch handshake stays in WAIT_FETCH
    be_redirect_valid = 1'b1; be_redirect_pc = 32'h6000; fetch_ready = 1'b1;
    step();
    be_redirect_valid = 1'b0;
    check("t4_override_valid", fetch_redirect_valid, 1);
    check("t4_override_pc", fetch_redirect_pc, 32'h6000);
    check("t4_be_cnt3", be_redirect_cnt, 3);
    step();  // handshake -> REFILL
    fetch_ready = 1'b0;
    check("t4_refill", fetch_redirect_valid, 0);
    step();
    step();
    check("t4_idle", busy, 0);

    // Stall passes through in IDLE, flush dominates after a redirect
    backend_stall = 1'b1;
    #1;
    check("t6_stall_idle", decode_stall, 1);
    be_redirect_valid = 1'b1; be_redirect_pc = 32'h7000;
    step();
    be_redirect_valid = 1'b0;
    check("t6_stall_masked", decode_stall, 0);
    check("t6_dflush", decode_flush, 1);
    check("t6_be_cnt4", be_redirect_cnt, 4);

    // Asynchronous reset in the middle of WAIT_FETCH
    backend_stall = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("t7_rst_valid", fetch_redirect_valid, 0);
    check("t7_rst_pc", fetch_redirect_pc, 0);
    check("t7_rst_fflush", fetch_flush, 0);
    check("t7_rst_dflush", decode_flush, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_stall", decode_stall, 0);
    check("t7_rst_be_cnt", be_redirect_cnt, 0);
    step();
    reset = 1'b1;
    step();

    // Drive the backend counter to saturation with back-to-back redirects
    be_redirect_valid = 1'b1; be_redirect_pc = 32'h8000; fetch_ready = 1'b1;
    repeat (65535) step();
    check("t5_cnt_full", be_redirect_cnt, 16'hFFFF);
    step();
    check("t5_cnt_sat", be_redirect_cnt, 16'hFFFF);
    counter_clr = 1'b1;
    step();
    counter_clr = 1'b0;
    check("t5_clr_wins", be_redirect_cnt, 0);
    step();
    be_redirect_valid = 1'b0;
    check("t5_count_again", be_redirect_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
